rc4_session_ctrl: RTL and testbench

//  Sequences one RC4 keystream generator (rc4 instance) per message session:

---
 rtl/rc4_ctrl_pkg.sv | 21 ++
 rtl/rc4_ks_buf.sv | 38 +++
 rtl/rc4_session_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_rc4_session_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_ctrl_pkg.sv
// Shared types and default widths for the RC4 session controller.
package rc4_ctrl_pkg;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned LEN_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        KS_RESET,
        INIT_WAIT,
        DROP,
        STREAM,
        DONE
    } state_t;

    // Larger of two sizes, used to dimension shared counters.
    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rc4_ks_buf.sv
// One-entry keystream skid buffer between the rc4 core and the XOR datapath.
// Requests a new byte only when empty or being consumed in the same cycle.
module rc4_ks_buf
    import rc4_ctrl_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         req_en,
    input  logic         consume,
    input  logic         ks_valid,
    input  logic [N-1:0] ks_byte,
    output logic         ks_req,
    output logic         buf_valid,
    output logic [N-1:0] buf_byte
);

    logic load;

    // A ks_valid without a matching request never overwrites the held byte.
    assign ks_req = req_en & (~buf_valid | consume);
    assign load   = ks_req & ks_valid;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            buf_valid <= 1'b0;
            buf_byte  <= '0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_byte  <= ks_byte;
        end else if (consume) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rc4_session_ctrl.sv
// Per-session sequencer for an external rc4 core: latches key, resets the core,
// waits for KSA completion, then XORs message bytes with keystream under valid/ready.
// Define RC4_DROP_EN to discard the first DROP_COUNT keystream bytes of each session.
module rc4_session_ctrl
    import rc4_ctrl_pkg::*;
#(
    parameter int unsigned N            = N_DEF,
    parameter int unsigned LEN_W        = LEN_W_DEF,
    parameter int unsigned RST_CYCLES   = 2,
    parameter int unsigned INIT_TIMEOUT = 1024,
    parameter int unsigned DROP_COUNT   = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N-1:0]     key_in,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready,
    output logic             ks_rst,
    output logic [N-1:0]     ks_password,
    output logic             ks_req,
    input  logic             ks_init_done,
    input  logic             ks_valid,
    input  logic [N-1:0]     ks_byte,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] byte_cnt
);

    localparam int unsigned CNT_MAX = umax(umax(RST_CYCLES, INIT_TIMEOUT), DROP_COUNT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

`ifdef RC4_DROP_EN
    localparam state_t POST_INIT = DROP;
`else
    localparam state_t POST_INIT = STREAM;
`endif

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_inc;
    logic               cnt_clr;
    logic               err_n;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   acc_cnt;
    logic               start_acc;
    logic               take_ok;
    logic               fire;
    logic               out_hs;
    logic               req_en;
    logic               consume;
    logic               buf_clear;
    logic               buf_valid;
    logic [N-1:0]       buf_byte;

    assign start_acc = (state == IDLE) & start & ~abort;
    assign out_hs    = out_valid & out_ready;

    // Input acceptance: keystream ready, output slot free, message not exhausted.
    assign take_ok  = (state == STREAM) & buf_valid & (~out_valid | out_ready) & (acc_cnt < len_q);
    assign in_ready = take_ok;
    assign fire     = take_ok & in_valid;

    assign req_en    = (state == STREAM) | (state == DROP);
    assign consume   = (state == DROP) ? buf_valid : fire;
    assign buf_clear = abort | ~req_en;

    rc4_ks_buf #(
        .N (N)
    ) u_ks_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .req_en    (req_en),
        .consume   (consume),
        .ks_valid  (ks_valid),
        .ks_byte   (ks_byte),
        .ks_req    (ks_req),
        .buf_valid (buf_valid),
        .buf_byte  (buf_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; cnt is a shared per-state timer cleared on every transition.
    always_comb begin
        state_n = state;
        cnt_inc = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start_acc) begin
                    state_n = (msg_len == '0) ? DONE : KS_RESET;
                end
            end
            KS_RESET: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_n = INIT_WAIT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            INIT_WAIT: begin
                if (ks_init_done) begin
                    state_n = POST_INIT;
                end else if (cnt == CNT_W'(INIT_TIMEOUT - 1)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`ifdef RC4_DROP_EN
            DROP: begin
                if (buf_valid) begin
                    if (cnt == CNT_W'(DROP_COUNT - 1)) begin
                        state_n = STREAM;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
`endif
            STREAM: begin
                if (out_hs && (byte_cnt == len_q - LEN_W'(1))) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort) begin
            state_n = IDLE;
            err_n   = 1'b0;
        end
    end

    assign cnt_clr = (state_n != state);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Session parameters and byte counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ks_password <= '0;
            len_q       <= '0;
            acc_cnt     <= '0;
            byte_cnt    <= '0;
        end else if (start_acc) begin
            ks_password <= key_in;
            len_q       <= msg_len;
            acc_cnt     <= '0;
            byte_cnt    <= '0;
        end else begin
            if (fire) begin
                acc_cnt <= acc_cnt + LEN_W'(1);
            end
            if ((state == STREAM) && out_hs) begin
                byte_cnt <= byte_cnt + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (abort) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ buf_byte;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Status outputs registered from the next state; a zero-length session keeps the core in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ks_rst <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            ks_rst <= (state_n == IDLE) || (state_n == KS_RESET)
                      || ((state_n == DONE) && (state == IDLE));
            busy   <= (state_n != IDLE);
            done   <= (state_n == DONE);
            err    <= err_n;
        end
    end

endmodule

// File: tb/tb_rc4_session_ctrl.sv
// Scoreboard bench for rc4_session_ctrl with an RC4 core stand-in and a reference RC4 keystream model.
// Honours RC4_DROP_EN the same way the design does.
module tb_rc4_session_ctrl;

    localparam int unsigned N            = 8;
    localparam int unsigned LEN_W        = 16;
    localparam int unsigned RST_CYCLES   = 2;
    localparam int unsigned INIT_TIMEOUT = 32;
    localparam int unsigned DROP_COUNT   = 4;
    localparam int          KS_LEN       = 512;
`ifdef RC4_DROP_EN
    localparam int DROP_OFS = DROP_COUNT;
`else
    localparam int DROP_OFS = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [N-1:0]     key_in;
    logic [LEN_W-1:0] msg_len;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic [N-1:0]     out_data;
    logic             out_ready;
    logic             ks_rst;
    logic [N-1:0]     ks_password;
    logic             ks_req;
    logic             ks_init_done;
    logic             ks_valid;
    logic [N-1:0]     ks_byte;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] byte_cnt;

    rc4_session_ctrl #(
        .N            (N),
        .LEN_W        (LEN_W),
        .RST_CYCLES   (RST_CYCLES),
        .INIT_TIMEOUT (INIT_TIMEOUT),
        .DROP_COUNT   (DROP_COUNT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .key_in       (key_in),
        .msg_len      (msg_len),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .ks_rst       (ks_rst),
        .ks_password  (ks_password),
        .ks_req       (ks_req),
        .ks_init_done (ks_init_done),
        .ks_valid     (ks_valid),
        .ks_byte      (ks_byte),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .byte_cnt     (byte_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int out_seen = 0;
    int done_cnt = 0;
    int last_hs_cyc = -1;
    int acc = 0;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] ks_tab[2][KS_LEN];
    bit src_en = 0, src_rand = 0, out_rand = 0, stall = 0;
    bit core_hang = 0, core_rand = 0, core_gen = 0;
    int core_idx = 0, core_wait = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    // Textbook RC4 with a one-byte key; slot 0 feeds the core stand-in, slot 1 the scoreboard.
    function automatic void rc4_fill(input int slot, input logic [7:0] key);
        int s[256];
        int i, j, t;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'(key)) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int n = 0; n < KS_LEN; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks_tab[slot][n] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endfunction

    always @(posedge clk) cyc++;

    // RC4 core stand-in: KSA delay after reset release, then keystream derived from ks_password.
    always @(negedge clk) begin
        if (ks_rst) begin
            core_idx = 0; core_wait = 0; core_gen = 0;
            ks_init_done = 1'b0; ks_valid = 1'b0; ks_byte = '0;
        end else begin
            if (!core_gen) begin
                rc4_fill(0, ks_password);
                core_gen = 1;
            end
            if (!ks_init_done) begin
                ks_valid = 1'b0;
                if (!core_hang && core_wait >= 3) ks_init_done = 1'b1;
                else core_wait++;
            end else begin
                ks_valid = !core_rand || ($urandom_range(3) != 0);
                ks_byte  = ks_tab[0][core_idx % KS_LEN];
            end
        end
        #1;
        if (ks_req && ks_valid) core_idx++;
    end

    // Plaintext source and downstream ready; expected ciphertext is queued on each accepted byte.
    always @(negedge clk) begin
        if (src_en && src_q.size() > 0 && (!src_rand || ($urandom_range(3) != 0))) begin
            in_valid = 1'b1;
            in_data  = src_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        out_ready = stall ? 1'b0 : (!out_rand || ($urandom_range(2) != 0));
        #1;
        if (in_valid && in_ready) begin
            exp_q.push_back(src_q[0] ^ ks_tab[1][(acc + DROP_OFS) % KS_LEN]);
            void'(src_q.pop_front());
            acc++;
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        #1;
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            chk("out_expected_pending", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            out_seen++;
            last_hs_cyc = cyc;
        end
    end

    task automatic run_session(input logic [7:0] k, input int len, input bit rnd, input bit do_stall);
        int base_seen, base_done, done_at;
        logic [7:0] hold;
        bit have_hold, got;
        rc4_fill(1, k);
        acc = 0; src_rand = rnd; out_rand = rnd; core_rand = rnd; src_en = 1;
        base_seen = out_seen; base_done = done_cnt; done_at = -1;
        @(negedge clk); start = 1'b1; key_in = k; msg_len = 16'(len);
        @(negedge clk); start = 1'b0; key_in = 8'($urandom); msg_len = 16'($urandom);
        #2;
        chk("busy_after_start", int'(busy), 1);
        chk("byte_cnt_cleared", int'(byte_cnt), 0);
        chk("ks_password", int'(ks_password), int'(k));
        if (do_stall) begin
            got = 0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk); #2;
                if (out_valid && (out_seen - base_seen >= 2)) got = 1;
            end
            chk("stall_reached", int'(got), 1);
            stall = 1; have_hold = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                start = (c == 2);
                msg_len = 16'(3);
                #2;
                if (out_valid) begin
                    if (!have_hold) begin
                        hold = out_data; have_hold = 1;
                    end else begin
                        chk("stall_out_stable", int'(out_data), int'(hold));
                    end
                    chk("stall_in_ready", int'(in_ready), 0);
                end
            end
            chk("stall_out_valid", int'(out_valid), 1);
            start = 1'b0;
            stall = 0;
        end
        for (int c = 0; c < 800 && done_at < 0; c++) begin
            @(negedge clk); #2;
            if (done) done_at = cyc;
        end
        chk("done_seen", int'(done_at >= 0), 1);
        chk("bytes_out", out_seen - base_seen, len);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("done_after_last", done_at, last_hs_cyc + 1);
        chk("byte_cnt_final", int'(byte_cnt), len);
        @(negedge clk); #2;
        chk("done_one_cycle", int'(done), 0);
        chk("idle_after_done", int'(busy), 0);
        chk("ks_rst_idle", int'(ks_rst), 1);
        chk("done_count", done_cnt - base_done, 1);
        chk("byte_cnt_held", int'(byte_cnt), len);
        src_en = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int len, s_cyc, err_at, base_done, base_seen, prev_cnt;
        bit got;
        rst = 1'b1; start = 1'b0; abort = 1'b0; key_in = '0; msg_len = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_ks_rst", int'(ks_rst), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_byte_cnt", int'(byte_cnt), 0);
        chk("rst_ks_password", int'(ks_password), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_ks_req", int'(ks_req), 0);
        @(negedge clk); rst = 1'b0;

        // Directed session: key 0x5A, bytes 01..04, downstream always ready.
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_session(8'h5A, 4, 0, 0);

        // Downstream stall mid-stream with a stray start while busy.
        src_q.delete();
        for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
        run_session(8'($urandom), 12, 0, 1);

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            len = $urandom_range(20, 1);
            src_q.delete();
            for (int i = 0; i < len; i++) src_q.push_back(8'($urandom));
            run_session(8'($urandom), len, 1, 0);
        end

        // Abort and start in the same cycle while idle: abort wins.
        prev_cnt = int'(byte_cnt);
        @(negedge clk); start = 1'b1; abort = 1'b1; msg_len = 16'(5);
        @(negedge clk); start = 1'b0; abort = 1'b0;
        #2;
        chk("abort_start_busy", int'(busy), 0);
        chk("abort_start_ks_rst", int'(ks_rst), 1);
        chk("abort_start_byte_cnt", int'(byte_cnt), prev_cnt);

        // Abort during STREAM after two bytes.
        src_q.delete();
        for (int i = 0; i < 10; i++) src_q.push_back(8'($urandom));
        rc4_fill(1, 8'hC3);
        acc = 0; src_rand = 0; out_rand = 0; core_rand = 0; src_en = 1;
        base_seen = out_seen; base_done = done_cnt;
        @(negedge clk); start = 1'b1; key_in = 8'hC3; msg_len = 16'(10);
        @(negedge clk); start = 1'b0;
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk); #2;
            if (out_seen - base_seen >= 2) got = 1;
        end
        chk("abort_two_bytes", int'(got), 1);
        src_en = 0; stall = 1;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        #2;
        chk("abort_busy", int'(busy), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_ks_rst", int'(ks_rst), 1);
        chk("abort_in_ready", int'(in_ready), 0);
        exp_q.delete(); src_q.delete();
        stall = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("abort_no_done", done_cnt - base_done, 0);

        // Core never finishes KSA: err pulse at the timeout.
        core_hang = 1;
        @(negedge clk); start = 1'b1; key_in = 8'h11; msg_len = 16'(5);
        @(negedge clk); start = 1'b0;
        s_cyc = cyc;
        err_at = -1;
        for (int c = 0; c < 3 * int'(INIT_TIMEOUT) && err_at < 0; c++) begin
            #2;
            if (err) err_at = cyc;
            else @(negedge clk);
        end
        chk("timeout_err_cycle", err_at, s_cyc + int'(RST_CYCLES) + int'(INIT_TIMEOUT));
        chk("timeout_busy", int'(busy), 0);
        @(negedge clk); #2;
        chk("timeout_err_pulse", int'(err), 0);
        core_hang = 0;

        // Zero-length session: immediate done, core stays in reset.
        base_done = done_cnt;
        @(negedge clk); start = 1'b1; key_in = 8'h77; msg_len = '0;
        @(negedge clk); start = 1'b0;
        #2;
        chk("zero_done", int'(done), 1);
        chk("zero_ks_rst", int'(ks_rst), 1);
        chk("zero_byte_cnt", int'(byte_cnt), 0);
        @(negedge clk); #2;
        chk("zero_done_pulse", int'(done), 0);
        chk("zero_idle", int'(busy), 0);
        chk("zero_done_count", done_cnt - base_done, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
